// File: rtl/maj_sweep_pkg.sv
// Shared parameters, selector codes, FSM states and truth-table type for the majority sweeper.
// MAJ_INV_EN widens each selector by one complement bit.
package maj_sweep_pkg;

    localparam int unsigned N_IN   = 7;
    localparam int unsigned N_GATE = 6;
`ifdef MAJ_INV_EN
    localparam int unsigned SEL_W  = 5;
`else
    localparam int unsigned SEL_W  = 4;
`endif
    localparam int unsigned CFG_W  = N_GATE * 3 * SEL_W;
    localparam int unsigned N_PAT  = 1 << N_IN;

    typedef logic [3:0] sel_code_t;

    localparam sel_code_t SEL_C0  = 4'd0;
    localparam sel_code_t SEL_C1  = 4'd1;
    localparam sel_code_t SEL_X0  = 4'd2;
    localparam sel_code_t SEL_W0  = 4'd9;
    localparam sel_code_t SEL_ILL = 4'd15;

    typedef enum logic [1:0] {IDLE, SWEEP, CMP, DONE} state_t;

    typedef logic [N_PAT-1:0] tt_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/maj_net_eval.sv
// Combinational evaluator for the 6-gate majority network on one input pattern.
// With MAJ_INV_EN the top selector bit complements the fanin after illegal->const0.
module maj_net_eval
    import maj_sweep_pkg::*;
(
    input  logic [CFG_W-1:0] cfg_i,
    input  logic [N_IN-1:0]  pat_i,
    output logic             out_o,
    output logic             ill_o
);

    logic [N_GATE-1:0] w;
    logic [SEL_W-1:0]  sel;
    sel_code_t         code;
    logic              v;
    logic [2:0]        fan;

    always_comb begin
        w     = '0;
        ill_o = 1'b0;
        sel   = '0;
        code  = SEL_C0;
        v     = 1'b0;
        fan   = '0;
        for (int unsigned g = 0; g < N_GATE; g++) begin
            for (int unsigned k = 0; k < 3; k++) begin
                sel  = cfg_i[(3*g+k)*SEL_W +: SEL_W];
                code = sel[3:0];
                v    = (code == SEL_C1);
                for (int unsigned n = 0; n < N_IN; n++) begin
                    if (code == SEL_X0 + sel_code_t'(n)) v = pat_i[n];
                end
                // Only earlier gates may feed gate g; anything else reads as const0.
                for (int unsigned j = 0; j < N_GATE; j++) begin
                    if (code == SEL_W0 + sel_code_t'(j)) begin
                        if (j < g) v = w[j];
                        else       ill_o = 1'b1;
                    end
                end
                if (code == SEL_ILL) ill_o = 1'b1;
`ifdef MAJ_INV_EN
                v = v ^ sel[SEL_W-1];
`endif
                fan[k] = v;
            end
            w[g] = maj3(fan[0], fan[1], fan[2]);
        end
        out_o = w[N_GATE-1];
    end

endmodule

// File: rtl/maj_tt_sweeper.sv
// Sweeps all 128 patterns through maj_net_eval, builds the truth table and classifies it
// against a target and its complement. Selector width follows MAJ_INV_EN.
module maj_tt_sweeper
    import maj_sweep_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CFG_W-1:0] cfg,
    input  logic [N_PAT-1:0] target_tt,
    output logic             busy,
    output logic             done,
    output logic [N_PAT-1:0] tt,
    output logic             match,
    output logic             match_neg,
    output logic             cfg_err
);

    state_t            state_q;
    logic [CFG_W-1:0]  cfg_q;
    tt_t               tgt_q;
    tt_t               tt_q, tt_d;
    logic [N_IN-1:0]   cnt_q;
    logic              busy_q, done_q, match_q, neg_q, err_q, err_d;
    logic              net_out, net_ill;

    maj_net_eval u_eval (
        .cfg_i (cfg_q),
        .pat_i (cnt_q),
        .out_o (net_out),
        .ill_o (net_ill)
    );

    // Shifting in from the top leaves pattern p at bit p after 128 cycles.
    assign tt_d  = {net_out, tt_q[N_PAT-1:1]};
    assign err_d = err_q | net_ill;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cfg_q   <= '0;
            tgt_q   <= '0;
            tt_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            match_q <= 1'b0;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= SWEEP;
                        cfg_q   <= cfg;
                        tgt_q   <= target_tt;
                        tt_q    <= '0;
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
                        match_q <= 1'b0;
                        neg_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                SWEEP: begin
                    tt_q  <= tt_d;
                    err_q <= err_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == '1) state_q <= CMP;
                end
                CMP: begin
                    match_q <= (tt_q == tgt_q);
                    neg_q   <= (tt_q == ~tgt_q);
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign tt        = tt_q;
    assign match     = match_q;
    assign match_neg = neg_q;
    assign cfg_err   = err_q;

endmodule

// File: tb/tb_maj_tt_sweeper.sv
// Table-driven bench for maj_tt_sweeper plus hand sequences for start-during-sweep,
// back-to-back start and asynchronous reset. Define MAJ_INV_EN to add the complement vector.
module tb_maj_tt_sweeper;
    import maj_sweep_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [CFG_W-1:0] cfg = '0;
    logic [127:0]     target_tt = '0;
    logic             busy, done, match, match_neg, cfg_err;
    logic [127:0]     tt;

    int errors = 0;
    int checks = 0;

    maj_tt_sweeper dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cfg       (cfg),
        .target_tt (target_tt),
        .busy      (busy),
        .done      (done),
        .tt        (tt),
        .match     (match),
        .match_neg (match_neg),
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CFG_W-1:0] cfg;
        logic [127:0]     tgt;
        logic [127:0]     ett;
        logic             em;
        logic             en;
        logic             ee;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [CFG_W-1:0] set_gate(input logic [CFG_W-1:0] c, input int g,
                                                  input int a, input int b, input int d);
        logic [CFG_W-1:0] r;
        r = c;
        r[(3*g+0)*SEL_W +: SEL_W] = SEL_W'(a);
        r[(3*g+1)*SEL_W +: SEL_W] = SEL_W'(b);
        r[(3*g+2)*SEL_W +: SEL_W] = SEL_W'(d);
        return r;
    endfunction

    function automatic logic [CFG_W-1:0] all_gates(input int code);
        logic [CFG_W-1:0] r;
        r = '0;
        for (int g = 0; g < 6; g++) r = set_gate(r, g, code, code, code);
        return r;
    endfunction

    function automatic logic [CFG_W-1:0] chain_cfg();
        logic [CFG_W-1:0] r;
        r = set_gate('0, 0, 2, 3, 4);
        for (int g = 1; g < 6; g++) r = set_gate(r, g, 9 + g - 1, 9 + g - 1, 9 + g - 1);
        return r;
    endfunction

    // Reference network: vote by counting ones over the three resolved fanins.
    function automatic logic [127:0] model_tt(input logic [CFG_W-1:0] c, output logic err);
        logic [127:0] r;
        logic [5:0]   w;
        int code, inv, f, ones;
        r = '0;
        err = 1'b0;
        for (int p = 0; p < 128; p++) begin
            w = '0;
            for (int g = 0; g < 6; g++) begin
                ones = 0;
                for (int k = 0; k < 3; k++) begin
                    code = int'(c[(3*g+k)*SEL_W +: 4]);
                    inv = 0;
`ifdef MAJ_INV_EN
                    inv = int'(c[(3*g+k)*SEL_W + 4]);
`endif
                    if (code == 0) f = 0;
                    else if (code == 1) f = 1;
                    else if (code <= 8) f = (p >> (code - 2)) & 1;
                    else if (code <= 14) begin
                        if (code - 9 < g) f = (int'(w) >> (code - 9)) & 1;
                        else begin f = 0; err = 1'b1; end
                    end else begin
                        f = 0;
                        err = 1'b1;
                    end
                    ones += f ^ inv;
                end
                w[g] = (ones >= 2);
            end
            r[p] = w[5];
        end
        return r;
    endfunction

    // Starts a sweep and returns the cycle (1 = first cycle after accept) in which done is seen.
    task automatic run(input logic [CFG_W-1:0] c, input logic [127:0] t, input int poke_at,
                       output int lat);
        cfg = c;
        target_tt = t;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        chk("busy_after_accept", 128'(busy), 128'(1'b1));
        while (!done && lat < 400) begin
            if (lat == poke_at) begin
                start = 1'b1;
                cfg = all_gates(1);
                target_tt = ~t;
            end else if (lat == poke_at + 1) begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
    endtask

    localparam logic [127:0] TT_X0  = 128'hAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAA;
    localparam logic [127:0] TT_MAJ = 128'hE8E8E8E8E8E8E8E8E8E8E8E8E8E8E8E8;
    localparam logic [127:0] TT_FWD = {64'hE8E8E8E8E8E8E8E8, 64'h0};

    initial begin : main
        vec_t v;
        int lat;
        logic merr;
        logic [127:0] mtt;
        logic [CFG_W-1:0] fwd;

        fwd = set_gate(chain_cfg(), 3, 13, 11, 8);
        vecs.push_back('{all_gates(2), TT_X0,   TT_X0,   1'b1, 1'b0, 1'b0});
        vecs.push_back('{chain_cfg(),  ~TT_MAJ, TT_MAJ,  1'b0, 1'b1, 1'b0});
        vecs.push_back('{chain_cfg(),  TT_MAJ,  TT_MAJ,  1'b1, 1'b0, 1'b0});
        vecs.push_back('{fwd,          '0,      TT_FWD,  1'b0, 1'b0, 1'b1});
        vecs.push_back('{all_gates(1), '0,      '1,      1'b0, 1'b1, 1'b0});
        vecs.push_back('{all_gates(15), '0,     '0,      1'b1, 1'b0, 1'b1});
`ifdef MAJ_INV_EN
        vecs.push_back('{all_gates(24), {64'h0, {64{1'b1}}}, {64'h0, {64{1'b1}}}, 1'b1, 1'b0, 1'b0});
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {tt[122:0], busy, done, match, match_neg, cfg_err}, '0);
        chk("rst_tt", tt, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            run(v.cfg, v.tgt, 0, lat);
            chk($sformatf("v%0d_latency", i), 128'(lat), 128'(130));
            chk($sformatf("v%0d_busy_at_done", i), 128'(busy), 128'(1'b0));
            chk($sformatf("v%0d_tt", i), tt, v.ett);
            mtt = model_tt(v.cfg, merr);
            chk($sformatf("v%0d_tt_model", i), tt, mtt);
            chk($sformatf("v%0d_match", i), 128'(match), 128'(v.em));
            chk($sformatf("v%0d_match_neg", i), 128'(match_neg), 128'(v.en));
            chk($sformatf("v%0d_cfg_err", i), 128'(cfg_err), 128'(v.ee));
            chk($sformatf("v%0d_err_model", i), 128'(cfg_err), 128'(merr));
            @(posedge clk); #1;
            chk($sformatf("v%0d_done_pulse", i), 128'(done), 128'(1'b0));
            chk($sformatf("v%0d_tt_hold", i), tt, v.ett);
        end

        // start during a sweep with cfg/target changed alongside: no effect on the run
        run(chain_cfg(), ~TT_MAJ, 50, lat);
        chk("poke_latency", 128'(lat), 128'(130));
        chk("poke_tt", tt, TT_MAJ);
        chk("poke_match_neg", {127'(0), match_neg}, 128'(1'b1));
        chk("poke_match", 128'(match), 128'(1'b0));

        // start held high through DONE: ignored there, accepted in the following IDLE cycle
        cfg = all_gates(2);
        target_tt = TT_X0;
        start = 1'b1;
        @(posedge clk); #1;
        chk("b2b_ignored_in_done", 128'(busy), 128'(1'b0));
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_accepted", 128'(busy), 128'(1'b1));
        chk("b2b_cleared_match", 128'(match_neg), 128'(1'b0));
        lat = 1;
        while (!done && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("b2b_latency", 128'(lat), 128'(130));
        chk("b2b_tt", tt, TT_X0);
        @(posedge clk); #1;

        // asynchronous reset in the middle of a sweep
        cfg = all_gates(1);
        target_tt = '0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (59) @(posedge clk);
        #2;
        chk("pre_rst_busy", 128'(busy), 128'(1'b1));
        chk("pre_rst_tt_nonzero", 128'(tt != '0), 128'(1'b1));
        rst_n = 1'b0;
        #1;
        chk("async_rst_flags", {123'(0), busy, done, match, match_neg, cfg_err}, '0);
        chk("async_rst_tt", tt, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_idle", 128'(busy), 128'(1'b0));
        run(all_gates(2), TT_X0, 0, lat);
        chk("post_rst_latency", 128'(lat), 128'(130));
        chk("post_rst_tt", tt, TT_X0);
        chk("post_rst_match", 128'(match), 128'(1'b1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/maj_tt_sweeper.md
# maj_tt_sweeper

Sequencer for a configurable 7-input, 6-gate majority-gate network in the function-classification flow. On a start request it latches a network configuration and drives all 128 input patterns through a shared combinational evaluator, one per cycle. It assembles the 128-bit truth table and compares it with a target function and with its complement. It is the control block that sits in front of the evaluator and feeds the classification bookkeeping.

## Interface
- N_IN, 7, number of primary inputs x0..x6 (fixed; pattern counter is N_IN bits wide)
- N_GATE, 6, number of 3-input majority gates w0..w5; network output is w[N_GATE-1]
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request a sweep; accepted only in IDLE
- cfg  in  N_GATE*3*SEL_W  fanin selectors; gate i fanin k at bits [(3*i+k)*SEL_W +: SEL_W]
- target_tt  in  128  function to classify against; bit p = f(pattern p)
- busy  out  1  high from the accept cycle until done
- done  out  1  one-cycle pulse when results are valid
- tt  out  128  truth table of the last sweep
- match  out  1  tt == target_tt
- match_neg  out  1  tt == ~target_tt
- cfg_err  out  1  last sweep used at least one illegal selector

## Operation
- Selector encoding (SEL_W=4): 0 = const0; 1 = const1; 2..8 = x0..x6; 9..14 = w0..w5; 15 = illegal.
- A selector referencing w_j is legal for gate i only when j < i. Illegal selectors evaluate as const0 and set cfg_err.
- Pattern p maps to inputs as x_n = p[n].
- FSM states:
  - IDLE: start=1 → SWEEP. cfg and target_tt are latched into internal registers; pattern counter, tt and cfg_err are cleared; match and match_neg are cleared.
  - SWEEP: each cycle tt[p] ← evaluator output, then p increments. At p=127 → CMP.
  - CMP: compute match and match_neg from tt and the latched target → DONE.
  - DONE: done=1 for one cycle → IDLE.
- start while not in IDLE is ignored; it is neither queued nor does it restart the sweep.
- Changes on cfg or target_tt after acceptance do not affect the running sweep.
- tt, match, match_neg and cfg_err hold their values from DONE until the next accepted start.
- Reset mid-sweep aborts immediately and returns the block to IDLE with all outputs at their reset values.

## Timing
- Reset values: busy=0, done=0, tt=0, match=0, match_neg=0, cfg_err=0; FSM in IDLE; counter 0.
- Start accepted on edge T0; busy=1 from T0+1.
- Pattern p is evaluated during cycle T0+1+p.
- CMP occurs at T0+129. done=1 and busy=0 in cycle T0+130.
- Total latency is 130 cycles from accept to done.
- A new start is accepted in the cycle after done, in IDLE. Back-to-back throughput is one sweep per 131 cycles.
- The evaluator is purely combinational between the counter/config registers and the tt shift-in; there is no extra pipeline stage.

## Configuration
- MAJ_INV_EN defined:
  - SEL_W = 5.
  - Bit 4 of each selector complements the selected fanin before the majority.
  - Complement is applied after the illegal→const0 substitution.
- MAJ_INV_EN undefined:
  - SEL_W = 4; no inversion logic exists.
  - cfg is 72 bits wide (90 bits with the macro).

## Structure
- Package maj_sweep_pkg holds:
  - N_IN, N_GATE, SEL_W (conditional on MAJ_INV_EN)
  - selector code constants SEL_C0, SEL_C1, SEL_X0, SEL_W0, SEL_ILL
  - FSM state enum: IDLE, SWEEP, CMP, DONE
  - the 128-bit truth-table typedef
- Sub-module maj_net_eval is combinational. It takes the latched cfg and a 7-bit pattern and returns the network output and an illegal-selector flag. The sweeper owns all state.

## Test plan
- All gates maj(x0,x0,x0), target=0xAAAA…AAAA → done at T0+130, tt=0xAAAA…AAAA, match=1, match_neg=0, cfg_err=0.
- Gate0=maj(x0,x1,x2), gates1..5 = maj(w_{i-1}, w_{i-1}, w_{i-1}) → tt[p] = majority of p[2:0]. Checked against the bench model over all 128 bits; with target = model complement → match=0, match_neg=1.
- Gate3 fanin0 selects w4 (forward reference) → cfg_err=1 and tt equals the model with that fanin as const0.
- start pulsed at T0+50 during a sweep, with cfg changed at the same time → ignored; results match the original cfg; done still at T0+130.
- rst_n low at T0+60 → all outputs 0 asynchronously. The next start after release completes a full 130-cycle sweep.
- With MAJ_INV_EN: all gates maj(~x6,~x6,~x6) → tt = ~(pattern bit6) = upper 64 bits 0, lower 64 bits 1.
